// File: rtl/ppf_commutator.sv
// ppf_commutator: serial-to-8-channel commutator feeding a polyphase filter bank, with resync drop tracking.
module ppf_commutator #(
  parameter int DATA_WIDTH    = 32,
  parameter int REVERSE_ORDER = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  din_valid_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  sync_i,
  output logic [DATA_WIDTH-1:0] channel0_data_o,
  output logic [DATA_WIDTH-1:0] channel1_data_o,
  output logic [DATA_WIDTH-1:0] channel2_data_o,
  output logic [DATA_WIDTH-1:0] channel3_data_o,
  output logic [DATA_WIDTH-1:0] channel4_data_o,
  output logic [DATA_WIDTH-1:0] channel5_data_o,
  output logic [DATA_WIDTH-1:0] channel6_data_o,
  output logic [DATA_WIDTH-1:0] channel7_data_o,
  output logic                  data_valid_o,
  output logic                  drop_o,
  output logic [15:0]           drop_cnt_o
);
  logic [2:0]            idx, wr_idx, slot;
  logic [DATA_WIDTH-1:0] col   [8];
  logic [DATA_WIDTH-1:0] ch    [8];
  logic [DATA_WIDTH-1:0] frame [8];
  assign wr_idx = sync_i ? 3'd0 : idx;
  assign slot   = (REVERSE_ORDER != 0) ? ~wr_idx : wr_idx;
  // Completed frame includes the sample arriving this cycle, so output lags the last sample by one edge.
  always_comb begin
    frame       = col;
    frame[slot] = din_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx          <= '0;
      col          <= '{default: '0};
      ch           <= '{default: '0};
      data_valid_o <= 1'b0;
      drop_o       <= 1'b0;
      drop_cnt_o   <= '0;
    end else begin
      data_valid_o <= 1'b0;
      drop_o       <= 1'b0;
      if (din_valid_i) begin
        col[slot] <= din_i;
        if (sync_i) begin
          idx <= 3'd1;
          if (idx != 3'd0) begin
            drop_o     <= 1'b1;
            drop_cnt_o <= (drop_cnt_o == 16'hFFFF) ? drop_cnt_o : drop_cnt_o + 16'd1;
          end
        end else begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            ch           <= frame;
            data_valid_o <= 1'b1;
          end
        end
      end
    end
  end
  assign channel0_data_o = ch[0];
  assign channel1_data_o = ch[1];
  assign channel2_data_o = ch[2];
  assign channel3_data_o = ch[3];
  assign channel4_data_o = ch[4];
  assign channel5_data_o = ch[5];
  assign channel6_data_o = ch[6];
  assign channel7_data_o = ch[7];
endmodule
